// File: rtl/counter_pkg.sv
// Shared types for the up/down counter: count width, count type and step direction.
package counter_pkg;

    localparam int COUNT_W = 4;

    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/updown_counter_if.sv
// Pin bundle for the up/down counter, used by the bench to drive and observe the DUT.
interface updown_counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNT_W
);
    logic             clk;
    logic             rst;
    logic             up;
    logic [WIDTH-1:0] dout;

    modport driver (output clk, output rst, output up, input dout);
    modport dut    (input clk, input rst, input up, output dout);
endinterface

// File: rtl/updown_next.sv
// Next-count logic: +1 or -1 modulo 2**WIDTH, no saturation.
module updown_next
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNT_W
) (
    input  logic [WIDTH-1:0] count,
    input  dir_e             dir,
    output logic [WIDTH-1:0] next
);

    // Width-truncated add/subtract gives the wrap at both ends for free.
    always_comb begin
        next = count;
        if (dir == DIR_UP) begin
            next = count + WIDTH'(1);
        end else begin
            next = count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Free-running up/down counter: async active-low reset register around updown_next.
module updown_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH       = COUNT_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;
    dir_e             dir;

    assign dir = up ? DIR_UP : DIR_DOWN;

    updown_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .count (count),
        .dir   (dir),
        .next  (count_next)
    );

    // Release is assumed already synchronised to clk upstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= RESET_VALUE;
        end else begin
            count <= count_next;
        end
    end

    assign dout = count;

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter: expected counts queued at drive time, popped after each edge.
module tb_updown_counter;
    import counter_pkg::*;

    updown_counter_if #(.WIDTH(COUNT_W)) bus ();

    updown_counter #(
        .WIDTH       (COUNT_W),
        .RESET_VALUE (4'h0)
    ) dut (
        .clk  (bus.clk),
        .rst  (bus.rst),
        .up   (bus.up),
        .dout (bus.dout)
    );

    int     n_checks = 0;
    int     n_pass   = 0;
    count_t model    = '0;
    count_t exp_q[$];

    initial bus.clk = 1'b0;
    always #5 bus.clk = ~bus.clk;

    task automatic check(input string tag, input logic [COUNT_W-1:0] got,
                         input logic [COUNT_W-1:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Written independently of the RTL arithmetic: explicit wrap at both ends.
    function automatic count_t model_next(input count_t cur, input logic u);
        if (u) return (cur == 4'hF) ? 4'h0 : count_t'(cur + 1);
        else   return (cur == 4'h0) ? 4'hF : count_t'(cur - 1);
    endfunction

    // Drive at the falling edge, score one rising edge later.
    task automatic step(input string tag, input logic u, input logic r);
        @(negedge bus.clk);
        bus.rst = r;
        bus.up  = u;
        if (r && $isunknown(u)) check("up_x_stimulus", 4'h1, 4'h0);
        if (r) model = model_next(model, u);
        else   model = 4'h0;
        exp_q.push_back(model);
        @(posedge bus.clk);
        #1;
        check(tag, bus.dout, exp_q.pop_front());
    endtask

    // Asynchronous assert midway between edges; must clear before the next edge.
    task automatic mid_reset();
        @(negedge bus.clk);
        bus.rst = 1'b0;
        model   = 4'h0;
        exp_q.push_back(model);
        #1;
        check("async_assert", bus.dout, exp_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rst = 1'b0;
        bus.up  = 1'b0;
        #2;
        check("reset_state", bus.dout, 4'h0);

        for (int i = 0; i < 3; i++) step("reset_hold", logic'(i[0]), 1'b0);
        for (int i = 0; i < 5; i++) step("release_up", 1'b1, 1'b1);
        check("release_up_5", bus.dout, 4'h5);

        mid_reset();
        for (int i = 1; i <= 17; i++) begin
            step("up_wrap", 1'b1, 1'b1);
            if (i == 15) check("up_wrap_max", bus.dout, 4'hF);
            if (i == 16) check("up_wrap_zero", bus.dout, 4'h0);
        end
        check("up_wrap_17", bus.dout, 4'h1);

        mid_reset();
        step("hold_low", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("down_wrap", 1'b0, 1'b1);
        check("down_wrap_13", bus.dout, 4'hD);

        mid_reset();
        step("hold_low", 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step("climb", 1'b1, 1'b1);
        check("at_seven", bus.dout, 4'h7);
        for (int i = 0; i < 4; i++) step("alternate", logic'(~i[0]), 1'b1);
        check("alternate_end", bus.dout, 4'h7);

        step("climb", 1'b1, 1'b1);
        step("climb", 1'b1, 1'b1);
        check("at_nine", bus.dout, 4'h9);
        mid_reset();
        for (int i = 0; i < 10; i++) step("long_hold", logic'(i[0]), 1'b0);
        step("release_after_hold", 1'b1, 1'b1);
        check("first_after_hold", bus.dout, 4'h1);

        for (int i = 0; i < 50; i++) begin
            if (i == 25 || i == 26) step("random_reset", 1'b1, 1'b0);
            else step("random", logic'($urandom_range(0, 1)), 1'b1);
        end

        if (exp_q.size() != 0) check("queue_drained", 4'(exp_q.size()), 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
